// File: rtl/i2s_dac_serializer.sv
// ---------------------------------------------------------------------------
// i2s_dac_serializer
//
// Purpose: I2S output stage between the audio FIFO and the DAC pins. Accepts
// stereo PCM pairs over valid/ready and serialises them MSB first in I2S
// format (one-bit delay after the lrclk edge, 32-bit slots, 64 bitclks per
// frame). All pin clocks are derived from sample_clk (1024 * fs_base).
//
// Optional feature macro: UNDERRUN_HOLD_EN
//   defined   - an underrun replays the last successfully loaded pair
//   undefined - an underrun sends digital silence (zeros)
//
// Ports:
//   sample_clk  in   XO clock, the only clock
//   rst         in   synchronous, active-high reset
//   enable      in   run request; low forces STOP
//   rate_sel    in   0 stop, 1 = 1x (bitclk /16), 2 = 2x (/8), 3 = 4x (/4)
//   s_valid     in   sample pair offered
//   s_ready     out  holding register can take the pair this cycle
//   s_left      in   left sample, two's complement
//   s_right     in   right sample, two's complement
//   tx_mclk     out  sample_clk / 2
//   tx_bitclk   out  64 * fs
//   tx_lrclk    out  0 = left slot, 1 = right slot
//   tx_data     out  serial data, MSB first
//   frame_start out  one-cycle pulse when the shifter loads a new frame
//   underrun    out  one-cycle pulse when the shifter loads with hold empty
// ---------------------------------------------------------------------------
module i2s_dac_serializer #(
  parameter int WIDTH = 24  // PCM bits per channel, at most 32
) (
  input  logic             sample_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       rate_sel,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             tx_mclk,
  output logic             tx_bitclk,
  output logic             tx_lrclk,
  output logic             tx_data,
  output logic             frame_start,
  output logic             underrun
);

  typedef enum logic [1:0] {ST_STOP, ST_SYNC, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       rate_q, rate_d;      // rate latched on leaving STOP
  logic [3:0]       div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [63:0]      frame_q, frame_d;    // whole frame, bit 63 goes out first
  logic             mclk_q, mclk_d, bitclk_q, bitclk_d, lrclk_q, lrclk_d;
  logic             data_q, data_d, frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
`ifdef UNDERRUN_HOLD_EN
  logic [WIDTH-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
`endif

  logic [1:0] tap;
  logic [3:0] tick_mask;
  logic       fall_tick, wrap, accept, stop_req;

  // Places a pair into its 32-bit slots; unused low slot bits stay zero.
  function automatic logic [63:0] pack_frame(input logic [WIDTH-1:0] l,
                                             input logic [WIDTH-1:0] r);
    logic [63:0] f;
    f = '0;
    f[63 -: WIDTH] = l;
    f[31 -: WIDTH] = r;
    return f;
  endfunction

  assign s_ready = !hold_full_q && (state_q != ST_STOP);

  // Divider tap k = 4 - rate; fall_tick when div_cnt[k:0] is all ones.
  always_comb begin
    case (rate_q)
      2'd1:    begin tap = 2'd3; tick_mask = 4'b1111; end
      2'd2:    begin tap = 2'd2; tick_mask = 4'b0111; end
      default: begin tap = 2'd1; tick_mask = 4'b0011; end
    endcase
  end

  // NOTE: every variable gets its default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    div_d         = div_q;
    bit_d         = bit_q;
    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    frame_d       = frame_q;
    data_d        = data_q;
    lrclk_d       = lrclk_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
`ifdef UNDERRUN_HOLD_EN
    last_l_d      = last_l_q;
    last_r_d      = last_r_q;
`endif

    fall_tick = (state_q != ST_STOP) && ((div_q & tick_mask) == tick_mask);
    wrap      = fall_tick && (bit_q == 6'd63);
    accept    = s_valid && s_ready;
    stop_req  = !enable || (rate_sel == 2'd0);

    case (state_q)
      ST_STOP: if (!stop_req) begin
        state_d = ST_SYNC;
        rate_d  = rate_sel;
      end
      // A rate change passes through STOP so the divider restarts cleanly.
      ST_SYNC: if (stop_req || rate_sel != rate_q) state_d = ST_STOP;
               else if (wrap && hold_full_q)       state_d = ST_RUN;
      ST_RUN:  if (stop_req || rate_sel != rate_q) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase

    if (state_q != ST_STOP) begin
      div_d = div_q + 4'd1;
      if (accept) begin
        hold_full_d = 1'b1;
        hold_l_d    = s_left;
        hold_r_d    = s_right;
      end
      if (fall_tick) begin
        bit_d = bit_q + 6'd1;
        if (wrap) begin
          if (hold_full_q) begin
            frame_d       = pack_frame(hold_l_q, hold_r_q);
            hold_full_d   = 1'b0;
            frame_start_d = 1'b1;
`ifdef UNDERRUN_HOLD_EN
            last_l_d      = hold_l_q;
            last_r_d      = hold_r_q;
`endif
          end else if (state_q == ST_RUN) begin
            // SYNC never reaches here: it waits for a full holding register.
`ifdef UNDERRUN_HOLD_EN
            frame_d       = pack_frame(last_l_q, last_r_q);
`else
            frame_d       = '0;
`endif
            frame_start_d = 1'b1;
            underrun_d    = 1'b1;
          end
        end else begin
          frame_d = frame_q << 1;
        end
        // Pins stay quiet in SYNC; they follow the slot counter once running.
        if (state_d == ST_RUN) begin
          data_d  = frame_d[63];
          lrclk_d = (bit_d >= 6'd31) && (bit_d != 6'd63);
        end
      end
    end

    // Entering STOP discards any frame in progress and any held pair.
    if (state_d == ST_STOP) begin
      div_d         = 4'd0;
      bit_d         = 6'd63;
      hold_full_d   = 1'b0;
      data_d        = 1'b0;
      lrclk_d       = 1'b0;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
`ifdef UNDERRUN_HOLD_EN
      last_l_d      = '0;
      last_r_d      = '0;
`endif
    end

    // Clock pins mirror the next divider value, so bitclk falls on the edge
    // right after fall_tick together with the data/lrclk update.
    bitclk_d = div_d[tap];
    mclk_d   = div_d[0];
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state_q       <= ST_STOP;
      rate_q        <= 2'd0;
      div_q         <= 4'd0;
      bit_q         <= 6'd63;
      hold_full_q   <= 1'b0;
      // NOTE: the data registers are reset as well, so nothing stale can ever
      // reach the pins after a reset.
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      frame_q       <= '0;
      mclk_q        <= 1'b0;
      bitclk_q      <= 1'b0;
      lrclk_q       <= 1'b0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
      last_l_q      <= '0;
      last_r_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      frame_q       <= frame_d;
      mclk_q        <= mclk_d;
      bitclk_q      <= bitclk_d;
      lrclk_q       <= lrclk_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
`ifdef UNDERRUN_HOLD_EN
      last_l_q      <= last_l_d;
      last_r_q      <= last_r_d;
`endif
    end
  end

  assign tx_mclk     = mclk_q;
  assign tx_bitclk   = bitclk_q;
  assign tx_lrclk    = lrclk_q;
  assign tx_data     = data_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
